// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared definitions for the FP add/sub sequencer: state
//               encoding, IEEE-754 single-precision field slices and
//               special constants.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_NORM  = 3'd2;
    localparam logic [2:0] ST_ROUND = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_PRE   = ST_PRE,
        S_NORM  = ST_NORM,
        S_ROUND = ST_ROUND,
        S_DONE  = ST_DONE
    } state_t;

    // IEEE-754 single constants
    localparam logic [7:0]  EXP_INF = 8'hFF;
    localparam int          BIAS    = 127;
    localparam int          MANT_W  = 28;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    // Field slices
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_W   = 23;

    // Working mantissa: bit27 carry headroom, bit26 hidden, [25:3] fraction, [2:0] G/R/S.
    // Subnormals have no hidden bit.
    function automatic logic [MANT_W-1:0] ext_mant(input logic [31:0] x);
        return {1'b0, (x[EXP_MSB:EXP_LSB] != 8'd0), x[FRAC_MSB:0], 3'b000};
    endfunction

    // Effective exponent: subnormals behave as exponent 1.
    function automatic logic [7:0] eff_exp(input logic [31:0] x);
        return (x[EXP_MSB:EXP_LSB] == 8'd0) ? 8'd1 : x[EXP_MSB:EXP_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_add_sequencer_preadder.sv
`default_nettype none
// ============================================================================
// Module      : preadder
// Description : Combinational front end of the FP adder. Detects NaN/Inf
//               operands, orders the operands by magnitude and aligns the
//               smaller mantissa to the larger exponent with sticky capture.
// Revision    : 1.0 - initial release
// ============================================================================
module preadder
    import fp_pkg::*;
(
    input  logic [31:0]       number_a,
    input  logic [31:0]       number_b,
    output logic              special_case,
    output logic [31:0]       special_result,
    output logic              sign_great,
    output logic              sign_small,
    output logic [7:0]        exp_great,
    output logic [MANT_W-1:0] mantis_great,
    output logic [MANT_W-1:0] mantis_small
);

    logic              w_sign_a, w_sign_b;
    logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    logic [7:0]        w_eexp_a, w_eexp_b, w_eexp_s, w_diff;
    logic [MANT_W-1:0] w_mant_a, w_mant_b, w_mant_s;
    logic [MANT_W-1:0] w_shifted, w_mask;
    logic              w_a_ge_b, w_sticky;

    assign w_sign_a = number_a[SIGN_BIT];
    assign w_sign_b = number_b[SIGN_BIT];
    assign w_nan_a  = (number_a[EXP_MSB:EXP_LSB] == EXP_INF) && (number_a[FRAC_MSB:0] != '0);
    assign w_nan_b  = (number_b[EXP_MSB:EXP_LSB] == EXP_INF) && (number_b[FRAC_MSB:0] != '0);
    assign w_inf_a  = (number_a[EXP_MSB:EXP_LSB] == EXP_INF) && (number_a[FRAC_MSB:0] == '0);
    assign w_inf_b  = (number_b[EXP_MSB:EXP_LSB] == EXP_INF) && (number_b[FRAC_MSB:0] == '0);
    assign w_eexp_a = eff_exp(number_a);
    assign w_eexp_b = eff_exp(number_b);
    assign w_mant_a = ext_mant(number_a);
    assign w_mant_b = ext_mant(number_b);

    // On equal magnitude A is treated as the greater operand
    assign w_a_ge_b = {w_eexp_a, w_mant_a} >= {w_eexp_b, w_mant_b};

    // Special results: any NaN or opposing infinities give a quiet NaN
    always_comb begin
        special_case   = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
        special_result = '0;
        if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a != w_sign_b)))
            special_result = QNAN;
        else if (w_inf_a)
            special_result = {w_sign_a, EXP_INF, {FRAC_W{1'b0}}};
        else if (w_inf_b)
            special_result = {w_sign_b, EXP_INF, {FRAC_W{1'b0}}};
    end

    // Operand ordering by magnitude
    always_comb begin
        sign_great   = w_a_ge_b ? w_sign_a : w_sign_b;
        sign_small   = w_a_ge_b ? w_sign_b : w_sign_a;
        exp_great    = w_a_ge_b ? w_eexp_a : w_eexp_b;
        mantis_great = w_a_ge_b ? w_mant_a : w_mant_b;
        w_mant_s     = w_a_ge_b ? w_mant_b : w_mant_a;
        w_eexp_s     = w_a_ge_b ? w_eexp_b : w_eexp_a;
    end

    // Alignment: bits shifted past the bottom are folded into the sticky bit
    assign w_diff       = exp_great - w_eexp_s;
    assign w_shifted    = w_mant_s >> w_diff;
    assign w_mask       = (w_diff >= 8'd28) ? {MANT_W{1'b1}} : ((28'd1 << w_diff) - 28'd1);
    assign w_sticky     = |(w_mant_s & w_mask);
    assign mantis_small = {w_shifted[MANT_W-1:1], w_shifted[0] | w_sticky};

endmodule
`default_nettype wire

// File: rtl/fp_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_sequencer
// Description : Multi-cycle single-precision FP add/sub controller. Captures
//               an operand pair, runs the preadder, adds mantissas, then
//               normalises one bit per cycle and rounds. One op in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_sequencer
    import fp_pkg::*;
#(
    parameter int ROUND_EN   = 1,
    parameter int NORM_LIMIT = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op_sub,
    input  logic [31:0] number_A,
    input  logic [31:0] number_B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        out_special,
    output logic        busy
);

    localparam int              ITER_W   = $clog2(NORM_LIMIT + 1);
    localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(NORM_LIMIT);

    state_t              r_state;
    logic                r_pre_phase;
    logic [31:0]         r_a, r_b;

    // Registered preadder outputs
    logic                r_pa_special;
    logic [31:0]         r_pa_special_result;
    logic                r_pa_sign_g, r_pa_sign_s;
    logic [7:0]          r_pa_exp;
    logic [MANT_W-1:0]   r_pa_mg, r_pa_ms;

    // Working datapath
    logic [MANT_W-1:0]   r_sum;
    logic [7:0]          r_exp;
    logic                r_sign;
    logic                r_subn;
    logic [ITER_W-1:0]   r_iter;

    // Preadder combinational outputs
    logic                w_special;
    logic [31:0]         w_special_result;
    logic                w_sign_g, w_sign_s;
    logic [7:0]          w_exp_g;
    logic [MANT_W-1:0]   w_mg, w_ms;

    logic                w_eff_sub;
    logic [MANT_W-1:0]   w_sum;
    logic                w_inc;
    logic [24:0]         w_rnd;

    preadder u_preadder (
        .number_a       (r_a),
        .number_b       (r_b),
        .special_case   (w_special),
        .special_result (w_special_result),
        .sign_great     (w_sign_g),
        .sign_small     (w_sign_s),
        .exp_great      (w_exp_g),
        .mantis_great   (w_mg),
        .mantis_small   (w_ms)
    );

    // Magnitude add/subtract on the registered, aligned mantissas
    assign w_eff_sub = r_pa_sign_g ^ r_pa_sign_s;
    assign w_sum     = w_eff_sub ? (r_pa_mg - r_pa_ms) : (r_pa_mg + r_pa_ms);

    // Round-to-nearest-even increment from guard, round, sticky and lsb
    assign w_inc = (ROUND_EN != 0) && r_sum[2] && (r_sum[1] || r_sum[0] || r_sum[3]);
    assign w_rnd = {1'b0, r_sum[26:3]} + {24'd0, w_inc};

    // Sequencer FSM with registered outputs and datapath state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state             <= S_IDLE;
            r_pre_phase         <= 1'b0;
            r_a                 <= '0;
            r_b                 <= '0;
            r_pa_special        <= 1'b0;
            r_pa_special_result <= '0;
            r_pa_sign_g         <= 1'b0;
            r_pa_sign_s         <= 1'b0;
            r_pa_exp            <= '0;
            r_pa_mg             <= '0;
            r_pa_ms             <= '0;
            r_sum               <= '0;
            r_exp               <= '0;
            r_sign              <= 1'b0;
            r_subn              <= 1'b0;
            r_iter              <= '0;
            in_ready            <= 1'b1;
            out_valid           <= 1'b0;
            result              <= '0;
            out_special         <= 1'b0;
            busy                <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a         <= number_A;
                        r_b         <= {number_B[SIGN_BIT] ^ op_sub, number_B[30:0]};
                        r_pre_phase <= 1'b0;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        out_special <= 1'b0;
                        r_state     <= S_PRE;
                    end
                end

                // First cycle registers the preadder; second cycle decides and adds
                S_PRE: begin
                    if (!r_pre_phase) begin
                        r_pa_special        <= w_special;
                        r_pa_special_result <= w_special_result;
                        r_pa_sign_g         <= w_sign_g;
                        r_pa_sign_s         <= w_sign_s;
                        r_pa_exp            <= w_exp_g;
                        r_pa_mg             <= w_mg;
                        r_pa_ms             <= w_ms;
                        r_pre_phase         <= 1'b1;
                    end else if (r_pa_special) begin
                        result      <= r_pa_special_result;
                        out_special <= 1'b1;
                        out_valid   <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_sum   <= w_sum;
                        r_exp   <= r_pa_exp;
                        r_sign  <= r_pa_sign_g;
                        r_subn  <= 1'b0;
                        r_iter  <= '0;
                        r_state <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (r_sum == '0) begin
                        result    <= 32'h0000_0000;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (r_sum[27]) begin
                        r_sum <= {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
                        r_exp <= r_exp + 8'd1;
                        if (r_exp == 8'd254) begin
                            result    <= {r_sign, EXP_INF, {FRAC_W{1'b0}}};
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_ROUND;
                        end
                    end else if (!r_sum[26] && (r_exp > 8'd1)) begin
                        if (r_iter >= ITER_MAX) begin
                            r_state <= S_ROUND;
                        end else begin
                            r_sum  <= r_sum << 1;
                            r_exp  <= r_exp - 8'd1;
                            r_iter <= r_iter + 1'b1;
                        end
                    end else if (!r_sum[26]) begin
                        r_subn  <= 1'b1;
                        r_state <= S_ROUND;
                    end else begin
                        r_state <= S_ROUND;
                    end
                end

                // Mantissa carry bumps the exponent; a subnormal rounding up becomes normal
                S_ROUND: begin
                    if (w_rnd[24]) begin
                        if (r_exp == 8'd254)
                            result <= {r_sign, EXP_INF, {FRAC_W{1'b0}}};
                        else
                            result <= {r_sign, r_exp + 8'd1, w_rnd[23:1]};
                    end else if (r_subn) begin
                        result <= {r_sign, (w_rnd[23] ? 8'd1 : 8'd0), w_rnd[22:0]};
                    end else begin
                        result <= {r_sign, r_exp, w_rnd[22:0]};
                    end
                    out_valid <= 1'b1;
                    r_state   <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
